// File: rtl/shapool_host_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shapool_host_pkg
// Purpose  : Shared op codes, FSM states and default widths for the SPI host.
//            SHAPOOL_HOST_READY_WAIT_EN adds the WAIT_READY state.
// Revision : 1.0
// ============================================================================
package shapool_host_pkg;

   localparam int DEFAULT_JOB_CONFIG_WIDTH    = 8;
   localparam int DEFAULT_DEVICE_CONFIG_WIDTH = 8;
   localparam int DEFAULT_RESULT_WIDTH        = 40;
   localparam int DEFAULT_SCK_HALF_PERIOD     = 3;

   localparam logic [1:0] OP_LOAD_JOB    = 2'd0;
   localparam logic [1:0] OP_LOAD_DEVICE = 2'd1;
   localparam logic [1:0] OP_READ_RESULT = 2'd2;
   localparam logic [1:0] OP_RESERVED    = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LEAD     = 3'd1,
      ST_SCK_HIGH = 3'd2,
      ST_SCK_LOW  = 3'd3,
      ST_TRAIL    = 3'd4,
      ST_GAP      = 3'd5
`ifdef SHAPOOL_HOST_READY_WAIT_EN
      , ST_WAIT_READY = 3'd6
`endif
   } host_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/shapool_spi_half_period_timer.sv
`default_nettype none
// ============================================================================
// Module   : shapool_spi_half_period_timer
// Purpose  : Emits a tick on the last cycle of each SCK half period; the count
//            restarts whenever the controlling FSM changes state.
// Revision : 1.0
// ============================================================================
module shapool_spi_half_period_timer #(
   parameter int HALF_PERIOD = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int                c_CW   = $clog2(HALF_PERIOD) + 1;
   localparam logic [c_CW-1:0]   c_LAST = c_CW'(HALF_PERIOD - 1);
   localparam logic [c_CW-1:0]   c_ONE  = c_CW'(1);

   logic [c_CW-1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (restart || tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + c_ONE;
      end
   end

   assign tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/shapool_spi_host.sv
`default_nettype none
// ============================================================================
// Module   : shapool_spi_host
// Purpose  : SPI mode-0 host for job/device config loads and result readback.
//            SHAPOOL_HOST_READY_WAIT_EN gates READ_RESULT on a device ready.
// Revision : 1.0
// ============================================================================
module shapool_spi_host
   import shapool_host_pkg::*;
#(
   parameter int JOB_CONFIG_WIDTH    = DEFAULT_JOB_CONFIG_WIDTH,
   parameter int DEVICE_CONFIG_WIDTH = DEFAULT_DEVICE_CONFIG_WIDTH,
   parameter int RESULT_WIDTH        = DEFAULT_RESULT_WIDTH,
   parameter int SCK_HALF_PERIOD     = DEFAULT_SCK_HALF_PERIOD
) (
   input  logic                           clk,
   input  logic                           reset_n,
`ifdef SHAPOOL_HOST_READY_WAIT_EN
   input  logic                           ready,
`endif
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [1:0]                     cmd_op,
   input  logic [JOB_CONFIG_WIDTH-1:0]    job_config_in,
   input  logic [DEVICE_CONFIG_WIDTH-1:0] device_config_in,
   output logic                           rsp_valid,
   output logic [RESULT_WIDTH-1:0]        rsp_result,
   output logic                           sck0,
   output logic                           sdo0,
   output logic                           cs0_n,
   output logic                           sck1,
   output logic                           sdo1,
   output logic                           cs1_n,
   input  logic                           sdi1
);

   localparam int c_TX_W   = max_int(JOB_CONFIG_WIDTH, DEVICE_CONFIG_WIDTH);
   localparam int c_MAX_W  = max_int(c_TX_W, RESULT_WIDTH);
   localparam int c_BIT_CW = $clog2(c_MAX_W + 1);

   localparam logic [c_BIT_CW-1:0] c_BITS_JOB = c_BIT_CW'(JOB_CONFIG_WIDTH);
   localparam logic [c_BIT_CW-1:0] c_BITS_DEV = c_BIT_CW'(DEVICE_CONFIG_WIDTH);
   localparam logic [c_BIT_CW-1:0] c_BITS_RES = c_BIT_CW'(RESULT_WIDTH);
   localparam logic [c_BIT_CW-1:0] c_BIT_ONE  = c_BIT_CW'(1);

   host_state_t               r_state, w_state_nxt;
   logic [1:0]                r_op, w_op_nxt;
   logic [c_TX_W-1:0]         r_tx, w_tx_nxt;
   logic [RESULT_WIDTH-1:0]   r_rx, w_rx_nxt;
   logic [RESULT_WIDTH-1:0]   r_rsp_result, w_rsp_result_nxt;
   logic [c_BIT_CW-1:0]       r_bits, w_bits_nxt;
   logic                      r_rsp_valid, w_rsp_valid_nxt;
   logic                      r_cs0_n, r_cs1_n, r_sck0, r_sck1, r_sdo0, r_sdo1;
   logic                      w_cs0_n_nxt, w_cs1_n_nxt, w_sck0_nxt, w_sck1_nxt;
   logic                      w_sdo0_nxt, w_sdo1_nxt;
   logic                      w_active_nxt;
   logic                      w_tick, w_restart;

`ifdef SHAPOOL_HOST_READY_WAIT_EN
   logic [1:0] r_ready_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ready_sync <= 2'b00;
      end else begin
         r_ready_sync <= {r_ready_sync[0], ready};
      end
   end
`endif

   shapool_spi_half_period_timer #(
      .HALF_PERIOD (SCK_HALF_PERIOD)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (w_restart),
      .tick    (w_tick)
   );

   assign w_restart = (w_state_nxt != r_state);

   always_comb begin
      w_state_nxt      = r_state;
      w_op_nxt         = r_op;
      w_tx_nxt         = r_tx;
      w_rx_nxt         = r_rx;
      w_bits_nxt       = r_bits;
      w_rsp_valid_nxt  = 1'b0;
      w_rsp_result_nxt = r_rsp_result;

      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_op_nxt   = cmd_op;
               w_rx_nxt   = '0;
               w_tx_nxt   = '0;
               w_bits_nxt = '0;
               case (cmd_op)
                  OP_LOAD_JOB: begin
                     // Left-justify so the MSB always sits at the top of the shifter.
                     w_tx_nxt    = c_TX_W'(job_config_in) << (c_TX_W - JOB_CONFIG_WIDTH);
                     w_bits_nxt  = c_BITS_JOB;
                     w_state_nxt = ST_LEAD;
                  end
                  OP_LOAD_DEVICE: begin
                     w_tx_nxt    = c_TX_W'(device_config_in) << (c_TX_W - DEVICE_CONFIG_WIDTH);
                     w_bits_nxt  = c_BITS_DEV;
                     w_state_nxt = ST_LEAD;
                  end
                  OP_READ_RESULT: begin
                     w_bits_nxt  = c_BITS_RES;
`ifdef SHAPOOL_HOST_READY_WAIT_EN
                     w_state_nxt = ST_WAIT_READY;
`else
                     w_state_nxt = ST_LEAD;
`endif
                  end
                  default: begin
                     w_rsp_valid_nxt = 1'b1;
                  end
               endcase
            end
         end
`ifdef SHAPOOL_HOST_READY_WAIT_EN
         ST_WAIT_READY: begin
            if (r_ready_sync[1]) begin
               w_state_nxt = ST_LEAD;
            end
         end
`endif
         ST_LEAD, ST_SCK_LOW: begin
            if (w_tick) begin
               w_state_nxt = ST_SCK_HIGH;
               // Captures sdi1 as it stood just before the rising SCK edge.
               if (r_op == OP_READ_RESULT) begin
                  w_rx_nxt = {r_rx[RESULT_WIDTH-2:0], sdi1};
               end
            end
         end
         ST_SCK_HIGH: begin
            if (w_tick) begin
               w_tx_nxt    = r_tx << 1;
               w_bits_nxt  = r_bits - c_BIT_ONE;
               w_state_nxt = (r_bits == c_BIT_ONE) ? ST_TRAIL : ST_SCK_LOW;
            end
         end
         ST_TRAIL: begin
            if (w_tick) begin
               w_state_nxt     = ST_GAP;
               w_rsp_valid_nxt = 1'b1;
               if (r_op == OP_READ_RESULT) begin
                  w_rsp_result_nxt = r_rx;
               end
            end
         end
         ST_GAP: begin
            if (w_tick) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Pin levels follow the upcoming state so every SPI output is a flop.
      w_active_nxt = (w_state_nxt == ST_LEAD)    || (w_state_nxt == ST_SCK_HIGH) ||
                     (w_state_nxt == ST_SCK_LOW) || (w_state_nxt == ST_TRAIL);
      w_cs0_n_nxt  = !(w_active_nxt && (w_op_nxt == OP_LOAD_JOB));
      w_cs1_n_nxt  = !(w_active_nxt && ((w_op_nxt == OP_LOAD_DEVICE) ||
                                        (w_op_nxt == OP_READ_RESULT)));
      w_sck0_nxt   = !w_cs0_n_nxt && (w_state_nxt == ST_SCK_HIGH);
      w_sck1_nxt   = !w_cs1_n_nxt && (w_state_nxt == ST_SCK_HIGH);
      w_sdo0_nxt   = !w_cs0_n_nxt && w_tx_nxt[c_TX_W-1];
      w_sdo1_nxt   = !w_cs1_n_nxt && (w_op_nxt == OP_LOAD_DEVICE) && w_tx_nxt[c_TX_W-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_op         <= OP_LOAD_JOB;
         r_tx         <= '0;
         r_rx         <= '0;
         r_bits       <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_cs0_n      <= 1'b1;
         r_cs1_n      <= 1'b1;
         r_sck0       <= 1'b0;
         r_sck1       <= 1'b0;
         r_sdo0       <= 1'b0;
         r_sdo1       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_op         <= w_op_nxt;
         r_tx         <= w_tx_nxt;
         r_rx         <= w_rx_nxt;
         r_bits       <= w_bits_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_result <= w_rsp_result_nxt;
         r_cs0_n      <= w_cs0_n_nxt;
         r_cs1_n      <= w_cs1_n_nxt;
         r_sck0       <= w_sck0_nxt;
         r_sck1       <= w_sck1_nxt;
         r_sdo0       <= w_sdo0_nxt;
         r_sdo1       <= w_sdo1_nxt;
      end
   end

   assign cmd_ready  = (r_state == ST_IDLE);
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign cs0_n      = r_cs0_n;
   assign cs1_n      = r_cs1_n;
   assign sck0       = r_sck0;
   assign sck1       = r_sck1;
   assign sdo0       = r_sdo0;
   assign sdo1       = r_sdo1;

endmodule
`default_nettype wire
